// File: rtl/design_select_ctrl.sv
// design_select_ctrl: configuration front-end for the design multiplexer.
// A 10-bit frame {magic[1:0], sync, hold, sel[5:0]} is shifted in MSB first and
// committed with cfg_latch. A commit that changes the select (and chip reset)
// starts a design_reset pulse lasting RST_CYCLES clocks.
//
// Ports:
//   clock           - sole clock, rising edge
//   reset           - asynchronous active-low reset
//   cfg_data        - serial configuration bit, MSB first
//   cfg_valid       - shift cfg_data in this cycle
//   cfg_latch       - single-cycle commit strobe
//   des_sel         - committed design select
//   hold_if_not_sel - committed hold control
//   sync_inputs     - committed input-synchroniser enable
//   design_reset    - active-high reset request for the selected design
//   busy            - high while a design_reset pulse is in progress
//   cfg_ack         - one-cycle pulse, commit accepted
//   cfg_err         - one-cycle pulse, commit rejected
module design_select_ctrl #(
  parameter int unsigned RST_CYCLES  = 8,
  parameter logic [5:0]  DEFAULT_SEL = 6'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cfg_data,
  input  logic       cfg_valid,
  input  logic       cfg_latch,
  output logic [5:0] des_sel,
  output logic       hold_if_not_sel,
  output logic       sync_inputs,
  output logic       design_reset,
  output logic       busy,
  output logic       cfg_ack,
  output logic       cfg_err
);

  localparam logic [7:0] RstLoad   = 8'(RST_CYCLES - 1);
  localparam logic [3:0] FrameBits = 4'd10;
  localparam logic [3:0] Overrun   = 4'd11;
  localparam logic [1:0] Magic     = 2'b10;

  typedef enum logic [0:0] {StIdle, StRst} state_e;

  state_e     state_q, state_d;
  logic [9:0] shift_q, shift_d;
  logic [3:0] bits_q, bits_d;
  logic [7:0] rst_cnt_q, rst_cnt_d;
  logic [5:0] sel_q, sel_d;
  logic       hold_q, hold_d;
  logic       sync_q, sync_d;
  logic       rst_out_q, rst_out_d;
  logic       busy_q, busy_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;

  logic       accept;
  logic       sel_changed;

  always_comb begin
    // The frame is judged on pre-shift contents, so a bit shifted alongside
    // the latch never influences the commit.
    accept      = cfg_latch && (bits_q == FrameBits) && (shift_q[9:8] == Magic) &&
                  (state_q == StIdle);
    sel_changed = (shift_q[5:0] != sel_q);

    shift_d   = shift_q;
    bits_d    = bits_q;
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    sel_d     = sel_q;
    hold_d    = hold_q;
    sync_d    = sync_q;

    if (cfg_latch) begin
      bits_d = 4'd0;
    end else if (cfg_valid) begin
      shift_d = {shift_q[8:0], cfg_data};
      bits_d  = (bits_q == Overrun) ? Overrun : bits_q + 4'd1;
    end

    if (accept) begin
      sel_d  = shift_q[5:0];
      hold_d = shift_q[6];
      sync_d = shift_q[7];
    end

    unique case (state_q)
      StIdle: begin
        if (accept && sel_changed) begin
          state_d   = StRst;
          rst_cnt_d = RstLoad;
        end
      end
      StRst: begin
        if (rst_cnt_q == 8'd0) begin
          state_d = StIdle;
        end else begin
          rst_cnt_d = rst_cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Pulse outputs follow the next state so they are plain flops.
    rst_out_d = (state_d == StRst);
    busy_d    = (state_d == StRst);
    ack_d     = accept;
    err_d     = cfg_latch && !accept;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StRst;
      shift_q   <= 10'd0;
      bits_q    <= 4'd0;
      rst_cnt_q <= RstLoad;
      sel_q     <= DEFAULT_SEL;
      hold_q    <= 1'b0;
      sync_q    <= 1'b1;
      rst_out_q <= 1'b1;
      busy_q    <= 1'b1;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bits_q    <= bits_d;
      rst_cnt_q <= rst_cnt_d;
      sel_q     <= sel_d;
      hold_q    <= hold_d;
      sync_q    <= sync_d;
      rst_out_q <= rst_out_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign des_sel         = sel_q;
  assign hold_if_not_sel = hold_q;
  assign sync_inputs     = sync_q;
  assign design_reset    = rst_out_q;
  assign busy            = busy_q;
  assign cfg_ack         = ack_q;
  assign cfg_err         = err_q;

endmodule

// File: tb/tb_design_select_ctrl.sv
// Self-checking bench for design_select_ctrl: directed scenarios followed by
// randomized frames, every cycle compared against a behavioural model.
module tb_design_select_ctrl;

  localparam int unsigned Rst = 8;

  logic       clock;
  logic       reset;
  logic       cfg_data;
  logic       cfg_valid;
  logic       cfg_latch;
  logic [5:0] des_sel;
  logic       hold_if_not_sel;
  logic       sync_inputs;
  logic       design_reset;
  logic       busy;
  logic       cfg_ack;
  logic       cfg_err;

  int checks = 0;
  int errors = 0;

  // Behavioural model: pulse length as "cycles of design_reset remaining".
  int         m_left;
  int         m_bits;
  logic [9:0] m_frame;
  logic [5:0] m_sel;
  logic       m_hold, m_sync, m_ack, m_err;

  design_select_ctrl #(
    .RST_CYCLES (Rst),
    .DEFAULT_SEL(6'd0)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cfg_data       (cfg_data),
    .cfg_valid      (cfg_valid),
    .cfg_latch      (cfg_latch),
    .des_sel        (des_sel),
    .hold_if_not_sel(hold_if_not_sel),
    .sync_inputs    (sync_inputs),
    .design_reset   (design_reset),
    .busy           (busy),
    .cfg_ack        (cfg_ack),
    .cfg_err        (cfg_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    m_left  = Rst;
    m_bits  = 0;
    m_frame = 10'd0;
    m_sel   = 6'd0;
    m_hold  = 1'b0;
    m_sync  = 1'b1;
    m_ack   = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic d, input logic l);
    bit ok;
    int next_left;
    ok        = l && (m_bits == 10) && (m_frame[9:8] == 2'b10) && (m_left == 0);
    next_left = (m_left > 0) ? m_left - 1 : 0;
    m_ack     = ok;
    m_err     = l && !ok;
    if (ok) begin
      if (m_frame[5:0] != m_sel) next_left = Rst;
      m_sel  = m_frame[5:0];
      m_hold = m_frame[6];
      m_sync = m_frame[7];
    end
    if (l) begin
      m_bits = 0;
    end else if (v) begin
      m_frame = {m_frame[8:0], d};
      m_bits  = (m_bits >= 11) ? 11 : m_bits + 1;
    end
    m_left = next_left;
  endtask

  task automatic check(input string tag);
    logic [10:0] obs, exp;
    obs = {des_sel, hold_if_not_sel, sync_inputs, design_reset, busy, cfg_ack, cfg_err};
    exp = {m_sel, m_hold, m_sync, m_left > 0, m_left > 0, m_ack, m_err};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%b expected=%b (sel,hold,sync,rst,busy,ack,err)",
               tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, model the edge, compare at the next negedge.
  task automatic tick(input string tag, input logic v, input logic d, input logic l);
    cfg_valid = v;
    cfg_data  = d;
    cfg_latch = l;
    @(posedge clock);
    model_edge(v, d, l);
    @(negedge clock);
    cfg_valid = 1'b0;
    cfg_data  = 1'b0;
    cfg_latch = 1'b0;
    check(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input string tag, input logic [15:0] f, input int n);
    for (int i = n - 1; i >= 0; i--) tick(tag, 1'b1, f[i], 1'b0);
  endtask

  task automatic latch(input string tag);
    tick(tag, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int guard = 0;
    while (m_left > 0 && guard < 40) begin
      tick(tag, 1'b0, 1'b0, 1'b0);
      guard++;
    end
  endtask

  // Assert reset between edges, check immediately, hold, then release.
  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1 model_reset();
    check({tag, "_immediate"});
    repeat (2) @(negedge clock);
    check({tag, "_held"});
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] f;
    logic [5:0]  rs;
    logic [1:0]  mg;
    int          n;

    reset     = 1'b0;
    cfg_data  = 1'b0;
    cfg_valid = 1'b0;
    cfg_latch = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    check("in_reset");
    reset = 1'b1;
    idle("rst_release", 10);

    // Basic commit: sel 5, hold 1, sync 0 -> pulse
    send("shift_sel5", 16'b10_0_1_000101, 10);
    latch("latch_sel5");
    check_val("sel5_des_sel", des_sel, 6'd5);
    check_val("sel5_hold", {5'd0, hold_if_not_sel}, 6'd1);
    check_val("sel5_sync", {5'd0, sync_inputs}, 6'd0);
    idle("sel5_pulse", 10);

    // Same select, sync change only: ack, no pulse
    send("shift_sync", 16'b10_1_1_000101, 10);
    latch("latch_sync");
    idle("sync_no_pulse", 3);
    check_val("sync_no_busy", {5'd0, busy}, 6'd0);

    // Malformed frames
    send("shift_9", 16'b10_0_0_000111, 9);
    latch("latch_9");
    idle("after_9", 2);
    send("shift_11", 16'b0_10_0_0_000111, 11);
    latch("latch_11");
    idle("after_11", 2);
    send("shift_magic01", 16'b01_0_0_000111, 10);
    latch("latch_magic01");
    idle("after_magic01", 2);
    check_val("malformed_keep_sel", des_sel, 6'd5);

    // Latch while busy, and on the cycle busy falls
    send("shift_sel7", 16'b10_1_0_000111, 10);
    latch("latch_sel7");
    latch("latch_busy");
    while (m_left > 1) tick("wait_last_busy", 1'b0, 1'b0, 1'b0);
    send("shift_sel9_early", 16'b10_1_0_001001, 0);
    latch("latch_busy_falls");
    send("shift_sel9", 16'b10_1_0_001001, 10);
    latch("latch_sel9");
    wait_idle("sel9_pulse");

    // Simultaneous valid+latch: bit dropped, counter back to 0
    send("shift_sel3", 16'b10_1_0_000011, 10);
    tick("valid_and_latch", 1'b1, 1'b1, 1'b1);
    check_val("vl_sel3", des_sel, 6'd3);
    wait_idle("sel3_pulse");
    send("shift_sel4", 16'b10_1_0_000100, 10);
    latch("latch_sel4");
    check_val("vl_sel4", des_sel, 6'd4);

    // Reset mid-pulse
    idle("sel4_partial", 3);
    async_reset("reset_mid_pulse");
    idle("pulse_restart", 10);

    // Reset mid-shift loses the partial frame
    send("shift_partial", 16'b10_1_0_001100, 6);
    async_reset("reset_mid_shift");
    idle("after_shift_reset", 9);
    send("shift_rest", 16'b10_1_0_001100, 4);
    latch("latch_partial");

    // Randomized frames against the model
    for (int i = 0; i < 60; i++) begin
      rs = 6'($urandom_range(0, 3));
      mg = ($urandom_range(0, 4) == 0) ? 2'b01 : 2'b10;
      f  = {5'd0, 1'b0, mg, 1'($urandom), 1'($urandom), rs};
      case ($urandom_range(0, 5))
        0:       n = 9;
        1:       n = 11;
        default: n = 10;
      endcase
      send("rand_shift", f, n);
      idle("rand_gap", $urandom_range(0, 3));
      tick("rand_latch", 1'($urandom_range(0, 3) == 0), 1'($urandom), 1'b1);
      idle("rand_idle", $urandom_range(0, 10));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
